// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants and state encoding for the UART receiver
//
// Purpose: default frame timing shared with the transmit side, and the
// receiver FSM state type.
// Ports: none (package).
package uart_rx_pkg;

  localparam int UART_CLKS_PER_BIT = 64;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and parallel byte output bundle of uart_rx
//
// Purpose: groups the serial line and the received-byte bus.
// Signals:
//   rxd          serial line into the receiver (idle high)
//   rx_data_o    last correctly framed byte
//   rx_valid     one-cycle strobe, rx_data_o is new
//   rx_frame_err one-cycle strobe, stop bit sampled low
//   rx_idle      receiver is waiting for a start edge
//   rx_bits_ok   one-cycle strobe at each data-bit sample
// Modports: slave = receiver side, master = line driver / byte consumer.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic                      rxd;
  logic [UART_DATA_BITS-1:0] rx_data_o;
  logic                      rx_valid;
  logic                      rx_frame_err;
  logic                      rx_idle;
  logic                      rx_bits_ok;

  modport slave (
    input  rxd,
    output rx_data_o, rx_valid, rx_frame_err, rx_idle, rx_bits_ok
  );

  modport master (
    output rxd,
    input  rx_data_o, rx_valid, rx_frame_err, rx_idle, rx_bits_ok
  );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rxd synchronizer with falling-edge detect
//
// Purpose: brings the asynchronous line into the sys_clk domain (s1, s2) and
// keeps one more delayed copy (s3) to detect a high-to-low transition.
// Ports:
//   sys_clk  clock
//   rst_n    synchronous active-low reset; all flops reset to 1 (idle line)
//   rxd      asynchronous serial input
//   rxd_s    synchronized line level (s2)
//   fall     one-cycle strobe on a synchronized falling edge
module uart_rx_sync (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rxd_s = s2;
  assign fall  = s3 & ~s2;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling
//
// Purpose: detects a start edge, checks the start bit at half a bit period,
// samples each data bit (LSB first) one bit period apart, then checks the
// stop bit. Good frames update rx_data_o with a one-cycle rx_valid; a low
// stop bit gives a one-cycle rx_frame_err and leaves rx_data_o unchanged.
// Ports:
//   sys_clk  clock, all logic on its rising edge
//   rst_n    synchronous active-low reset
//   rx       uart_rx_if.slave: rxd in; rx_data_o, rx_valid, rx_frame_err,
//            rx_idle, rx_bits_ok out
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic     sys_clk,
  input  logic     rst_n,
  uart_rx_if.slave rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  logic rxd_s;
  logic fall;

  uart_rx_sync u_sync (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .rxd     (rx.rxd),
    .rxd_s   (rxd_s),
    .fall    (fall)
  );

  rx_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   bits_ok_q, bits_ok_d;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      bits_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      bits_ok_q <= bits_ok_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    bits_ok_d = 1'b0;

    case (state_q)
      RX_IDLE: begin
        // Only an edge starts a frame, so a line stuck low stays here.
        cnt_d = '0;
        if (fall) begin
          state_d = RX_START;
        end
      end

      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxd_s) begin
            state_d = RX_DATA;
            idx_d   = '0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_d = RX_IDLE;
          end
        end
      end

      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxd_s;
          bits_ok_d      = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = RX_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      RX_STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch a following
        // start edge with no idle gap.
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rxd_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx.rx_data_o    = data_q;
  assign rx.rx_valid     = valid_q;
  assign rx.rx_frame_err = err_q;
  assign rx.rx_bits_ok   = bits_ok_q;
  assign rx.rx_idle      = (state_q == RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  localparam int CPB = 64;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;

  always #5 sys_clk = ~sys_clk;

  uart_rx_if rif ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .rx      (rif)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  int          cyc          = 0;
  int          valid_cnt    = 0;
  int          err_cnt      = 0;
  int          bits_ok_cnt  = 0;
  int          overlap_cnt  = 0;
  int          last_valid_cyc = 0;
  int          idle_high_cnt = 0;
  logic        watch_idle   = 1'b0;
  logic        prev_pulse   = 1'b0;
  logic [7:0]  rx_q[$];

  // Monitor samples 2 time units after each rising edge.
  always begin
    @(posedge sys_clk);
    cyc++;
    #2;
    if (rif.rx_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      rx_q.push_back(rif.rx_data_o);
    end
    if (rif.rx_frame_err === 1'b1) err_cnt++;
    if (rif.rx_bits_ok === 1'b1) bits_ok_cnt++;
    if ((rif.rx_valid === 1'b1) && (rif.rx_frame_err === 1'b1)) overlap_cnt++;
    if (prev_pulse && ((rif.rx_valid === 1'b1) || (rif.rx_frame_err === 1'b1))) overlap_cnt++;
    prev_pulse = (rif.rx_valid === 1'b1) || (rif.rx_frame_err === 1'b1);
    if (watch_idle && (rif.rx_idle !== 1'b0)) idle_high_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Caller must be at a falling edge.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rif.rxd = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rif.rxd = b[i];
      repeat (CPB) @(negedge sys_clk);
    end
    rif.rxd = stop;
    repeat (CPB) @(negedge sys_clk);
    rif.rxd = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rif.rxd = 1'b1;
    repeat (n * CPB) @(negedge sys_clk);
  endtask

  task automatic pop_byte(output logic [7:0] b);
    if (rx_q.size() > 0) b = rx_q.pop_front();
    else b = 8'hxx;
  endtask

  task automatic test_reset();
    rif.rxd = 1'b1;
    rst_n   = 1'b0;
    repeat (4) @(negedge sys_clk);
    total_cnt++; if (rif.rx_data_o !== 8'h00) $display("FAIL reset_data: got %h want 00", rif.rx_data_o); else pass_cnt++;
    total_cnt++; if (rif.rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rif.rx_valid); else pass_cnt++;
    total_cnt++; if (rif.rx_frame_err !== 1'b0) $display("FAIL reset_err: got %b want 0", rif.rx_frame_err); else pass_cnt++;
    total_cnt++; if (rif.rx_bits_ok !== 1'b0) $display("FAIL reset_bits_ok: got %b want 0", rif.rx_bits_ok); else pass_cnt++;
    total_cnt++; if (rif.rx_idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", rif.rx_idle); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_single();
    int v0, e0, b0, start_cyc, lat;
    logic [7:0] got;
    idle_bits(2);
    rx_q.delete();
    v0 = valid_cnt; e0 = err_cnt; b0 = bits_ok_cnt;
    start_cyc = cyc;
    send_byte(8'h6E, 1'b1);
    idle_bits(1);
    lat = last_valid_cyc - start_cyc;
    total_cnt++; if (valid_cnt - v0 !== 1) $display("FAIL single_valid_count: got %0d want 1", valid_cnt - v0); else pass_cnt++;
    pop_byte(got);
    total_cnt++; if (got !== 8'h6E) $display("FAIL single_data: got %h want 6e", got); else pass_cnt++;
    total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL single_err: got %0d want 0", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (bits_ok_cnt - b0 !== 8) $display("FAIL single_bits_ok: got %0d want 8", bits_ok_cnt - b0); else pass_cnt++;
    // 2 synchronizer cycles to fall detect, then 608 cycles +/-1.
    total_cnt++; if (lat < 609 || lat > 611) $display("FAIL single_latency: got %0d want 609..611", lat); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int v0;
    logic [7:0] got;
    rx_q.delete();
    v0 = valid_cnt;
    idle_high_cnt = 0;
    fork
      begin
        send_byte(8'hF0, 1'b1);
        send_byte(8'h0F, 1'b1);
      end
      begin
        for (int f = 0; f < 2; f++) begin
          repeat (8) @(negedge sys_clk);
          watch_idle = 1'b1;
          repeat (592) @(negedge sys_clk);
          watch_idle = 1'b0;
          repeat (40) @(negedge sys_clk);
        end
      end
    join
    idle_bits(3);
    send_byte(8'hA5, 1'b1);
    idle_bits(1);
    total_cnt++; if (valid_cnt - v0 !== 3) $display("FAIL b2b_valid_count: got %0d want 3", valid_cnt - v0); else pass_cnt++;
    pop_byte(got);
    total_cnt++; if (got !== 8'hF0) $display("FAIL b2b_data0: got %h want f0", got); else pass_cnt++;
    pop_byte(got);
    total_cnt++; if (got !== 8'h0F) $display("FAIL b2b_data1: got %h want 0f", got); else pass_cnt++;
    pop_byte(got);
    total_cnt++; if (got !== 8'hA5) $display("FAIL b2b_data2: got %h want a5", got); else pass_cnt++;
    total_cnt++; if (idle_high_cnt !== 0) $display("FAIL b2b_idle_low: got %0d idle cycles want 0", idle_high_cnt); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    rif.rxd = 1'b0;
    repeat (10) @(negedge sys_clk);
    total_cnt++; if (rif.rx_idle !== 1'b0) $display("FAIL glitch_in_start: got idle %b want 0", rif.rx_idle); else pass_cnt++;
    repeat (10) @(negedge sys_clk);
    rif.rxd = 1'b1;
    repeat (20) @(negedge sys_clk);
    total_cnt++; if (rif.rx_idle !== 1'b1) $display("FAIL glitch_idle_return: got idle %b want 1", rif.rx_idle); else pass_cnt++;
    repeat (700) @(negedge sys_clk);
    total_cnt++; if ((valid_cnt - v0) + (err_cnt - e0) !== 0) $display("FAIL glitch_no_pulse: got %0d pulses want 0", (valid_cnt - v0) + (err_cnt - e0)); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int v0, e0;
    logic [7:0] got;
    rx_q.delete();
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h3C, 1'b0);
    idle_bits(1);
    total_cnt++; if (err_cnt - e0 !== 1) $display("FAIL ferr_err_count: got %0d want 1", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (valid_cnt - v0 !== 0) $display("FAIL ferr_no_valid: got %0d want 0", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (rif.rx_data_o !== 8'hA5) $display("FAIL ferr_data_held: got %h want a5", rif.rx_data_o); else pass_cnt++;
    send_byte(8'h55, 1'b1);
    idle_bits(1);
    pop_byte(got);
    total_cnt++; if (got !== 8'h55) $display("FAIL ferr_recover: got %h want 55", got); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    logic [7:0] b;
    logic [7:0] got;
    b = 8'hF3;
    rx_q.delete();
    v0 = valid_cnt; e0 = err_cnt;
    rif.rxd = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      rif.rxd = b[i];
      repeat (CPB) @(negedge sys_clk);
    end
    rif.rxd = b[4];
    repeat (CPB / 2) @(negedge sys_clk);
    rst_n = 1'b0;
    @(posedge sys_clk);
    #2;
    total_cnt++; if (rif.rx_idle !== 1'b1) $display("FAIL rstmid_idle: got %b want 1", rif.rx_idle); else pass_cnt++;
    total_cnt++; if (rif.rx_data_o !== 8'h00) $display("FAIL rstmid_data: got %h want 00", rif.rx_data_o); else pass_cnt++;
    total_cnt++; if ({rif.rx_valid, rif.rx_frame_err, rif.rx_bits_ok} !== 3'b000) $display("FAIL rstmid_pulses: got %b want 000", {rif.rx_valid, rif.rx_frame_err, rif.rx_bits_ok}); else pass_cnt++;
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (CPB / 2 - 1) @(negedge sys_clk);
    for (int i = 5; i < 8; i++) begin
      rif.rxd = b[i];
      repeat (CPB) @(negedge sys_clk);
    end
    rif.rxd = 1'b1;
    repeat (CPB) @(negedge sys_clk);
    idle_bits(1);
    total_cnt++; if ((valid_cnt - v0) + (err_cnt - e0) !== 0) $display("FAIL rstmid_no_pulse: got %0d pulses want 0", (valid_cnt - v0) + (err_cnt - e0)); else pass_cnt++;
    send_byte(8'h81, 1'b1);
    idle_bits(1);
    pop_byte(got);
    total_cnt++; if (got !== 8'h81) $display("FAIL rstmid_next_frame: got %h want 81", got); else pass_cnt++;
  endtask

  task automatic test_break();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    rif.rxd = 1'b0;
    repeat (25 * CPB) @(negedge sys_clk);
    total_cnt++; if (err_cnt - e0 !== 1) $display("FAIL break_err_count: got %0d want 1", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (rif.rx_idle !== 1'b1) $display("FAIL break_idle: got %b want 1", rif.rx_idle); else pass_cnt++;
    idle_bits(2);
    total_cnt++; if (valid_cnt - v0 !== 0) $display("FAIL break_no_valid: got %0d want 0", valid_cnt - v0); else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [7:0] seq [4];
    logic [7:0] got;
    int e0;
    seq[0] = 8'h6E; seq[1] = 8'hF0; seq[2] = 8'h0F; seq[3] = 8'hA5;
    rx_q.delete();
    e0 = err_cnt;
    for (int i = 0; i < 4; i++) send_byte(seq[i], 1'b1);
    idle_bits(1);
    for (int i = 0; i < 4; i++) begin
      pop_byte(got);
      total_cnt++; if (got !== seq[i]) $display("FAIL stream_data%0d: got %h want %h", i, got, seq[i]); else pass_cnt++;
    end
    total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL stream_err: got %0d want 0", err_cnt - e0); else pass_cnt++;
  endtask

  initial begin
    rif.rxd = 1'b1;
    @(negedge sys_clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_break();
    test_stream();
    total_cnt++; if (overlap_cnt !== 0) $display("FAIL pulse_exclusive: got %0d overlaps want 0", overlap_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
